// File: rtl/branch_history_table.sv
// Branch history table: 2-bit saturating-style prediction counters with one-cycle lookup,
// commit-time training and commit/mispredict statistics. Optional macro: BHT_BYPASS_EN.
module branch_history_table #(
  parameter int IDX_W  = 8,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              clear,
  input  logic              lk_valid,
  input  logic [IDX_W-1:0]  lk_idx,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_miss,
  input  logic              upd_hit,
  input  logic [IDX_W-1:0]  upd_idx,
  output logic [STAT_W-1:0] stat_commit,
  output logic [STAT_W-1:0] stat_miss
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]        ctr_r [ENTRIES];
  logic              pred_valid_r;
  logic              pred_taken_r;
  logic [IDX_W-1:0]  pred_idx_r;
  logic [STAT_W-1:0] stat_commit_r;
  logic [STAT_W-1:0] stat_miss_r;

  logic              upd_any_s;
  logic [1:0]        upd_cur_s;
  logic [1:0]        upd_nxt_s;
  logic [1:0]        lk_rd_s;
  logic [1:0]        lk_ctr_s;

  // Mispredict moves toward the opposite weak state; a correct prediction strengthens.
  function automatic logic [1:0] train_ctr(input logic [1:0] cur, input logic miss);
    logic [1:0] nxt;
    if (miss) begin
      case (cur)
        2'b00:   nxt = 2'b01;
        2'b01:   nxt = 2'b10;
        2'b10:   nxt = 2'b01;
        2'b11:   nxt = 2'b10;
        default: nxt = 2'b01;
      endcase
    end else begin
      case (cur)
        2'b00:   nxt = 2'b00;
        2'b01:   nxt = 2'b00;
        2'b10:   nxt = 2'b11;
        2'b11:   nxt = 2'b11;
        default: nxt = 2'b01;
      endcase
    end
    return nxt;
  endfunction

  // Training value for the commit index and the counter seen by this cycle's lookup.
  always_comb begin
    upd_any_s = upd_miss | upd_hit;
    upd_cur_s = ctr_r[upd_idx];
    upd_nxt_s = train_ctr(upd_cur_s, upd_miss);
    lk_rd_s   = ctr_r[lk_idx];
`ifdef BHT_BYPASS_EN
    if (upd_any_s && (upd_idx == lk_idx)) begin
      lk_ctr_s = upd_nxt_s;
    end else begin
      lk_ctr_s = lk_rd_s;
    end
`else
    lk_ctr_s  = lk_rd_s;
`endif
  end

  // Counter array: trained on commit, untouched by pipeline flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= 2'b01;
      end
    end else if (rdy && upd_any_s) begin
      ctr_r[upd_idx] <= upd_nxt_s;
    end
  end

  // Registered prediction; a flush kills the in-flight lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_r <= 1'b0;
      pred_taken_r <= 1'b0;
      pred_idx_r   <= '0;
    end else if (rdy) begin
      pred_valid_r <= lk_valid & ~clear;
      pred_taken_r <= lk_ctr_s[1];
      pred_idx_r   <= lk_idx;
    end
  end

  // Statistics: a simultaneous hit+miss counts as a single mispredicted commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_commit_r <= '0;
      stat_miss_r   <= '0;
    end else if (rdy) begin
      if (upd_any_s) begin
        stat_commit_r <= stat_commit_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end
      if (upd_miss) begin
        stat_miss_r <= stat_miss_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign pred_valid  = pred_valid_r;
  assign pred_taken  = pred_taken_r;
  assign pred_idx    = pred_idx_r;
  assign stat_commit = stat_commit_r;
  assign stat_miss   = stat_miss_r;

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table: directed vector table, mid-cycle reset,
// full-table sweep and randomized traffic against an arithmetic reference model.
module tb_branch_history_table;

  localparam int IDX_W  = 8;
  localparam int STAT_W = 32;
  localparam int N      = 1 << IDX_W;
`ifdef BHT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, rdy, clear, lk_valid, upd_miss, upd_hit;
  logic [IDX_W-1:0]  lk_idx, upd_idx, pred_idx;
  logic              pred_valid, pred_taken;
  logic [STAT_W-1:0] stat_commit, stat_miss;

  branch_history_table #(.IDX_W(IDX_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .lk_valid(lk_valid), .lk_idx(lk_idx),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
    .upd_miss(upd_miss), .upd_hit(upd_hit), .upd_idx(upd_idx),
    .stat_commit(stat_commit), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: counters as integers 0..3 (>=2 means taken).
  int               m_ctr [N];
  bit               m_pv, m_pt;
  logic [IDX_W-1:0] m_pi;
  logic [STAT_W-1:0] m_sc, m_sm;

  function automatic int next_ctr(int c, bit miss);
    if (miss) return (c < 2) ? c + 1 : c - 1;
    if (c < 2) return (c == 0) ? 0 : c - 1;
    return 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_ctr[i] = 1;
    m_pv = 1'b0; m_pt = 1'b0; m_pi = '0; m_sc = '0; m_sm = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("pred_valid", {31'd0, pred_valid}, {31'd0, m_pv});
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_pt});
    chk("pred_idx",   {24'd0, pred_idx},   {24'd0, m_pi});
    chk("stat_commit", stat_commit, m_sc);
    chk("stat_miss",   stat_miss,   m_sm);
  endtask

  // One clock: drive inputs, advance the model, cross the edge, compare 1 time unit later.
  task automatic step(input bit r, input bit c, input bit lv, input logic [IDX_W-1:0] li,
                      input bit m, input bit h, input logic [IDX_W-1:0] ui);
    int val;
    rdy = r; clear = c; lk_valid = lv; lk_idx = li;
    upd_miss = m; upd_hit = h; upd_idx = ui;
    if (r) begin
      val = m_ctr[li];
      if ((m || h) && BYP && (li == ui)) val = next_ctr(m_ctr[ui], m);
      m_pv = lv && !c;
      m_pt = (val >= 2);
      m_pi = li;
      if (m || h) begin
        m_ctr[ui] = next_ctr(m_ctr[ui], m);
        m_sc = m_sc + 32'd1;
      end
      if (m) m_sm = m_sm + 32'd1;
    end
    @(posedge clk);
    #1;
    chk_model();
  endtask

  typedef struct {
    bit rdy, clr, lkv;
    logic [7:0] lki;
    bit miss, hit;
    logic [7:0] ui;
    bit pv, pt;
    logic [7:0] pi;
    logic [31:0] sc, sm;
  } vec_t;

  vec_t vt [21];

  initial begin
    vt[0]  = '{1'b1,1'b0,1'b1,8'd5,1'b0,1'b0,8'd0, 1'b1,1'b0,8'd5,32'd0,32'd0};
    vt[1]  = '{1'b1,1'b0,1'b0,8'd0,1'b0,1'b0,8'd0, 1'b0,1'b0,8'd0,32'd0,32'd0};
    vt[2]  = '{1'b1,1'b0,1'b0,8'd0,1'b1,1'b0,8'd5, 1'b0,1'b0,8'd0,32'd1,32'd1};
    vt[3]  = '{1'b1,1'b0,1'b1,8'd5,1'b0,1'b0,8'd0, 1'b1,1'b1,8'd5,32'd1,32'd1};
    vt[4]  = '{1'b1,1'b0,1'b0,8'd0,1'b1,1'b0,8'd5, 1'b0,1'b0,8'd0,32'd2,32'd2};
    vt[5]  = '{1'b1,1'b0,1'b1,8'd5,1'b0,1'b0,8'd0, 1'b1,1'b0,8'd5,32'd2,32'd2};
    vt[6]  = '{1'b1,1'b0,1'b0,8'd0,1'b1,1'b0,8'd9, 1'b0,1'b0,8'd0,32'd3,32'd3};
    vt[7]  = '{1'b1,1'b0,1'b0,8'd0,1'b0,1'b1,8'd9, 1'b0,1'b0,8'd0,32'd4,32'd3};
    vt[8]  = '{1'b1,1'b0,1'b0,8'd0,1'b0,1'b1,8'd9, 1'b0,1'b0,8'd0,32'd5,32'd3};
    vt[9]  = '{1'b1,1'b0,1'b0,8'd0,1'b0,1'b1,8'd9, 1'b0,1'b0,8'd0,32'd6,32'd3};
    vt[10] = '{1'b1,1'b0,1'b1,8'd9,1'b0,1'b0,8'd0, 1'b1,1'b1,8'd9,32'd6,32'd3};
    vt[11] = '{1'b1,1'b0,1'b0,8'd0,1'b1,1'b0,8'd9, 1'b0,1'b0,8'd0,32'd7,32'd4};
    vt[12] = '{1'b1,1'b0,1'b1,8'd9,1'b0,1'b0,8'd0, 1'b1,1'b1,8'd9,32'd7,32'd4};
    vt[13] = '{1'b1,1'b0,1'b1,8'd7,1'b1,1'b0,8'd7, 1'b1,BYP, 8'd7,32'd8,32'd5};
    vt[14] = '{1'b1,1'b0,1'b1,8'd7,1'b0,1'b0,8'd0, 1'b1,1'b1,8'd7,32'd8,32'd5};
    vt[15] = '{1'b1,1'b1,1'b1,8'd3,1'b0,1'b1,8'd3, 1'b0,1'b0,8'd3,32'd9,32'd5};
    vt[16] = '{1'b0,1'b0,1'b1,8'd3,1'b1,1'b0,8'd3, 1'b0,1'b0,8'd3,32'd9,32'd5};
    vt[17] = '{1'b1,1'b0,1'b1,8'd3,1'b0,1'b0,8'd0, 1'b1,1'b0,8'd3,32'd9,32'd5};
    vt[18] = '{1'b1,1'b0,1'b0,8'd0,1'b1,1'b0,8'd3, 1'b0,1'b0,8'd0,32'd10,32'd6};
    vt[19] = '{1'b1,1'b0,1'b0,8'd0,1'b1,1'b0,8'd3, 1'b0,1'b0,8'd0,32'd11,32'd7};
    vt[20] = '{1'b1,1'b0,1'b1,8'd3,1'b0,1'b0,8'd0, 1'b1,1'b1,8'd3,32'd11,32'd7};

    rst_n = 1'b0; rdy = 1'b0; clear = 1'b0; lk_valid = 1'b0; lk_idx = '0;
    upd_miss = 1'b0; upd_hit = 1'b0; upd_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset pred_valid", {31'd0, pred_valid}, 32'd0);
    chk("reset pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("reset pred_idx", {24'd0, pred_idx}, 32'd0);
    chk("reset stat_commit", stat_commit, 32'd0);
    chk("reset stat_miss", stat_miss, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, compared to hand-derived values and to the model.
    for (int i = 0; i < 21; i++) begin
      step(vt[i].rdy, vt[i].clr, vt[i].lkv, vt[i].lki, vt[i].miss, vt[i].hit, vt[i].ui);
      chk($sformatf("vec%0d pred_valid", i), {31'd0, pred_valid}, {31'd0, vt[i].pv});
      chk($sformatf("vec%0d pred_taken", i), {31'd0, pred_taken}, {31'd0, vt[i].pt});
      chk($sformatf("vec%0d pred_idx", i), {24'd0, pred_idx}, {24'd0, vt[i].pi});
      chk($sformatf("vec%0d stat_commit", i), stat_commit, vt[i].sc);
      chk($sformatf("vec%0d stat_miss", i), stat_miss, vt[i].sm);
    end

    // One cycle later an un-repeated lookup must drop pred_valid.
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    chk("single-cycle valid", {31'd0, pred_valid}, 32'd0);

    // Mid-cycle asynchronous reset while a taken prediction is presented.
    step(1'b1, 1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 8'd0);
    chk("pre-reset pred_valid", {31'd0, pred_valid}, 32'd1);
    chk("pre-reset pred_taken", {31'd0, pred_taken}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async pred_valid", {31'd0, pred_valid}, 32'd0);
    chk("async pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("async pred_idx", {24'd0, pred_idx}, 32'd0);
    chk("async stat_commit", stat_commit, 32'd0);
    chk("async stat_miss", stat_miss, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Every entry must read back weak-not-taken after reset.
    for (int i = 0; i < N; i++) begin
      step(1'b1, 1'b0, 1'b1, i[7:0], 1'b0, 1'b0, 8'd0);
      chk($sformatf("sweep%0d taken", i), {31'd0, pred_taken}, 32'd0);
    end

    // Randomized traffic; narrow index range often forces lookup/update collisions.
    for (int n = 0; n < 3000; n++) begin
      bit r, c, lv, m, h;
      logic [7:0] li, ui;
      int kind;
      r  = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 9) == 0);
      lv = ($urandom_range(0, 9) < 7);
      kind = $urandom_range(0, 2);
      m  = (kind == 1);
      h  = (kind == 2);
      if ($urandom_range(0, 3) == 0) begin
        li = 8'($urandom_range(0, 255));
        ui = 8'($urandom_range(0, 255));
      end else begin
        li = 8'($urandom_range(0, 7));
        ui = 8'($urandom_range(0, 7));
      end
      step(r, c, lv, li, m, h, ui);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
